// File: rtl/seg_scan_capture.sv
// Receive side of an 8-digit multiplexed seven-segment bus. It samples each stable, lit
// digit, decodes the segments back to nibbles and presents whole frames on valid/ready.
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  AN,
    input  logic [6:0]  HEX,
    input  logic        DP,
    output logic [31:0] value_o,
    output logic [7:0]  blank_o,
    output logic [7:0]  unknown_o,
    output logic [7:0]  dp_o,
    output logic        frame_valid_o,
    input  logic        frame_ready_i,
    output logic        overrun_o,
    output logic        idle_o
);
    localparam int DW = $clog2(STABLE_CYCLES + 2);
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [7:0]    an_meta_reg, an_sync_reg;
    logic [6:0]    hex_meta_reg, hex_sync_reg;
    logic          dp_meta_reg, dp_sync_reg;
    logic [15:0]   triple_cur, triple_prev_reg;
    logic [DW-1:0] dwell_reg, dwell_now;
    logic [7:0]    sel_n, capture_bit, mask_reg, mask_next;
    logic          an_onehot, sample;
    logic [5:0]    dec;
    logic [31:0]   shadow_value_reg, shadow_value_next, value_reg;
    logic [7:0]    shadow_blank_reg, shadow_blank_next, blank_reg;
    logic [7:0]    shadow_unknown_reg, shadow_unknown_next, unknown_reg;
    logic [7:0]    shadow_dp_reg, shadow_dp_next, dp_reg;
    logic          frame_valid_reg, overrun_reg, idle_reg, idle_next;
    logic          complete, xfer, load, timeout_hit;
    logic [IW-1:0] idle_cnt_reg, idle_cnt_next;

    // Returns {unknown, blank, nibble} for an active-low segment pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40: decode_seg = 6'h00;
            7'h79: decode_seg = 6'h01;
            7'h24: decode_seg = 6'h02;
            7'h30: decode_seg = 6'h03;
            7'h19: decode_seg = 6'h04;
            7'h12: decode_seg = 6'h05;
            7'h02: decode_seg = 6'h06;
            7'h78: decode_seg = 6'h07;
            7'h00: decode_seg = 6'h08;
            7'h10: decode_seg = 6'h09;
            7'h08: decode_seg = 6'h0A;
            7'h03: decode_seg = 6'h0B;
            7'h46: decode_seg = 6'h0C;
            7'h21: decode_seg = 6'h0D;
            7'h06: decode_seg = 6'h0E;
            7'h0E: decode_seg = 6'h0F;
            7'h7F: decode_seg = 6'h10;
            default: decode_seg = 6'h20;
        endcase
    endfunction

    assign triple_cur = {an_sync_reg, hex_sync_reg, dp_sync_reg};
    assign sel_n      = ~an_sync_reg;
    assign an_onehot  = (sel_n != 8'h00) && ((sel_n & (sel_n - 8'd1)) == 8'h00);
    assign dec        = decode_seg(hex_sync_reg);

    // dwell_now is the run length of the current triple including this cycle; it parks one
    // past STABLE_CYCLES so a long dwell is sampled only once.
    always_comb begin
        dwell_now = dwell_reg;
        if (triple_cur != triple_prev_reg)
            dwell_now = DW'(1);
        else if (dwell_reg != DW'(STABLE_CYCLES + 1))
            dwell_now = dwell_reg + DW'(1);
    end

    assign sample      = an_onehot && (dwell_now == DW'(STABLE_CYCLES));
    assign capture_bit = sample ? sel_n : 8'h00;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shadow
            assign shadow_value_next[4*gi +: 4] = capture_bit[gi] ? dec[3:0] : shadow_value_reg[4*gi +: 4];
            assign shadow_blank_next[gi]        = capture_bit[gi] ? dec[4]   : shadow_blank_reg[gi];
            assign shadow_unknown_next[gi]      = capture_bit[gi] ? dec[5]   : shadow_unknown_reg[gi];
            assign shadow_dp_next[gi]           = capture_bit[gi] ? ~dp_sync_reg : shadow_dp_reg[gi];
        end
    endgenerate

    always_comb begin
        complete      = (mask_reg == 8'hFF);
        xfer          = frame_valid_reg & frame_ready_i;
        load          = complete && (!frame_valid_reg || xfer);
        // A capture in the terminal cycle takes priority over the timeout.
        timeout_hit   = !sample && (idle_cnt_reg == IW'(TIMEOUT - 1));
        mask_next     = ((complete || timeout_hit) ? 8'h00 : mask_reg) | capture_bit;
        idle_cnt_next = idle_cnt_reg;
        idle_next     = idle_reg;
        if (sample) begin
            idle_cnt_next = '0;
            idle_next     = 1'b0;
        end else if (idle_cnt_reg != IW'(TIMEOUT)) begin
            idle_cnt_next = idle_cnt_reg + IW'(1);
            if (timeout_hit)
                idle_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_meta_reg        <= 8'hFF;
            an_sync_reg        <= 8'hFF;
            hex_meta_reg       <= 7'h7F;
            hex_sync_reg       <= 7'h7F;
            dp_meta_reg        <= 1'b1;
            dp_sync_reg        <= 1'b1;
            triple_prev_reg    <= 16'hFFFF;
            dwell_reg          <= '0;
            mask_reg           <= 8'h00;
            shadow_value_reg   <= 32'h0;
            shadow_blank_reg   <= 8'h00;
            shadow_unknown_reg <= 8'h00;
            shadow_dp_reg      <= 8'h00;
            value_reg          <= 32'h0;
            blank_reg          <= 8'h00;
            unknown_reg        <= 8'h00;
            dp_reg             <= 8'h00;
            frame_valid_reg    <= 1'b0;
            overrun_reg        <= 1'b0;
            idle_reg           <= 1'b0;
            idle_cnt_reg       <= '0;
        end else begin
            an_meta_reg        <= AN;
            an_sync_reg        <= an_meta_reg;
            hex_meta_reg       <= HEX;
            hex_sync_reg       <= hex_meta_reg;
            dp_meta_reg        <= DP;
            dp_sync_reg        <= dp_meta_reg;
            triple_prev_reg    <= triple_cur;
            dwell_reg          <= dwell_now;
            mask_reg           <= mask_next;
            shadow_value_reg   <= shadow_value_next;
            shadow_blank_reg   <= shadow_blank_next;
            shadow_unknown_reg <= shadow_unknown_next;
            shadow_dp_reg      <= shadow_dp_next;
            idle_reg           <= idle_next;
            idle_cnt_reg       <= idle_cnt_next;
            overrun_reg        <= complete && !load;
            if (load) begin
                value_reg       <= shadow_value_reg;
                blank_reg       <= shadow_blank_reg;
                unknown_reg     <= shadow_unknown_reg;
                dp_reg          <= shadow_dp_reg;
                frame_valid_reg <= 1'b1;
            end else if (xfer) begin
                frame_valid_reg <= 1'b0;
            end
        end
    end

    assign value_o       = value_reg;
    assign blank_o       = blank_reg;
    assign unknown_o     = unknown_reg;
    assign dp_o          = dp_reg;
    assign frame_valid_o = frame_valid_reg;
    assign overrun_o     = overrun_reg;
    assign idle_o        = idle_reg;
endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side counterpart of the 8-digit multiplexed seven-segment driver: samples a scanned AN/HEX/DP bus, decodes each lit digit's segment pattern back to a hex nibble, and assembles a full 8-digit frame. Presents completed frames on a valid/ready interface. Sits in loopback/self-check builds, fed by the display driver outputs or external pins, driving a checker, logger or UART.

## Interface
- STABLE_CYCLES, 4: synchronised bus must hold unchanged this many cycles before a digit is sampled (min 1)
- TIMEOUT, 20000: cycles without any digit capture before the partial frame is dropped
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-low reset
- AN  in  8  anode selects, active-low, one-hot-low expected; bit k selects digit k
- HEX  in  7  segments, active-low, HEX[0]=a … HEX[6]=g
- DP  in  1  decimal point, active-low
- value_o  out  32  digit k nibble in value_o[4k+3:4k]
- blank_o  out  8  bit k: digit k had all segments off (HEX=7'h7F)
- unknown_o  out  8  bit k: digit k pattern is not a hex glyph or blank
- dp_o  out  8  bit k: DP of digit k was lit
- frame_valid_o  out  1  frame available
- frame_ready_i  in  1  consumer accepts frame
- overrun_o  out  1  one-cycle pulse: completed frame discarded
- idle_o  out  1  timeout occurred; no capture since

## Operation
- AN, HEX, DP each pass a 2-flop synchroniser; everything below uses the synchronised values.
- Stability: triple {AN,HEX,DP} compared with the previous cycle's triple; any difference restarts the dwell count. Sample exactly once per dwell, on the cycle the triple has been identical for STABLE_CYCLES consecutive cycles. Longer dwells do not resample.
- AN valid only if exactly one bit is 0. Non-one-hot dwells (all ones, multiple zeros) are never sampled and never count as captures.
- Decode (active-low HEX → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - 7F: nibble 0, blank bit 1.
  - Any other pattern: nibble 0, unknown bit 1.
  - dp bit = ~DP.
- A sample writes digit k's shadow entry and sets captured-mask bit k. A repeat capture of the same digit overwrites the entry.
- Frame completion: on the cycle the mask becomes 8'hFF:
  - If frame_valid_o=0, or a transfer occurs in that same cycle: shadow copies into the output regs, frame_valid_o=1, mask clears.
  - Otherwise: outputs are held, the new frame is dropped, overrun_o pulses, mask clears.
- Handshake: transfer when frame_valid_o & frame_ready_i. frame_valid_o falls the next cycle unless a new frame loads in the transfer cycle. Outputs stay stable while frame_valid_o=1.
- Timeout: idle counter increments every cycle without a capture and resets on capture. On reaching TIMEOUT: mask clears, idle_o=1, counter saturates. The next capture clears idle_o.

## Timing
- Reset (async assert, sync release):
  - value_o=0, blank_o=0, unknown_o=0, dp_o=0, frame_valid_o=0, overrun_o=0, idle_o=0.
  - Mask, shadow, dwell and idle counters cleared; synchronisers set to 1 (all-off bus).
- Pin-to-capture latency: 2 + STABLE_CYCLES cycles after a clean bus change.
- Eighth capture to frame_valid_o: 1 cycle.
- Reset mid-frame discards the partial frame and any pending frame_valid_o.
- Simultaneous completion and transfer: new frame loads, frame_valid_o stays 1, no overrun.
- Simultaneous capture and timeout terminal count: capture wins; no mask clear, idle_o stays 0.

## Test plan
- Scan digits 0..7 showing F,E,D,C,B,A,9,8, dwell 10 cycles each, ready=1 → one frame: value_o=32'h89ABCDEF, blank_o=0, unknown_o=0, frame_valid_o high 1 cycle.
- Same scan, but digit 3 also dwells 2 cycles with HEX=7'h00 (glitch) → glitch ignored, value_o=32'h89ABCDEF. Digit 5 pattern 7'h55 → unknown_o=8'h20, nibble 5=0.
- ready=0 over two full scans → first frame held; overrun_o pulses once at second completion. Raise ready → transfer, frame_valid_o drops next cycle.
- Four digits captured, then AN=8'hFF for TIMEOUT cycles → idle_o=1, mask cleared. A following full scan yields exactly one correct frame, with no stale digits.
- AN=8'hFC dwelling 50 cycles → no capture, no frame. Assert reset mid-scan → all outputs 0 immediately; the next full scan produces a correct frame.
